// File: rtl/jtcomsc_pcm_ctrl_if.sv
// Sample-ROM fetch port of the ADPCM playback sequencer.
// The sequencer drives address/request; the ROM side answers with data and a valid flag.
interface jtcomsc_pcm_ctrl_if #(
  parameter int unsigned AW = 16
);
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic [7:0]    rom_data;
  logic          rom_ok;

  modport master (output rom_addr, rom_cs, input rom_data, rom_ok);
  modport slave  (input rom_addr, rom_cs, output rom_data, rom_ok);
endinterface

// File: rtl/jtcomsc_pcm_ctrl.sv
// Combat School ADPCM voice sequencer: CPU-programmed page range, one-byte ROM
// prefetch and nibble delivery to the decoder on each sample-rate enable.
module jtcomsc_pcm_ctrl #(
  parameter int unsigned AW       = 16,
  parameter bit          HI_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cs_i,
  input  logic                wr_n_i,
  input  logic [1:0]          addr_i,
  input  logic [7:0]          din_i,
  output logic [7:0]          dout_o,
  output logic                busy_o,
  jtcomsc_pcm_ctrl_if.master  rom,
  input  logic                cen_smp_i,
  output logic [3:0]          pcm_data_o,
  output logic                pcm_vld_o,
  output logic                pcm_rst_o,
  output logic                underrun_o
);

  localparam int unsigned PW = AW - 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic          wq_q, wq_d;
  logic [PW-1:0] start_pg_q, start_pg_d;
  logic [PW-1:0] end_pg_q, end_pg_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          first_q, first_d;
  logic          rom_cs_q, rom_cs_d;
  logic [7:0]    buf_q, buf_d;
  logic [7:0]    shift_q, shift_d;
  logic          full_q, full_d;
  logic          last_q, last_d;
  logic          phase_q, phase_d;
  logic          busy_q, busy_d;
  logic          pcm_rst_q, pcm_rst_d;
  logic [3:0]    pcm_data_q, pcm_data_d;
  logic          pcm_vld_q, pcm_vld_d;
  logic          underrun_q, underrun_d;

  logic wq_c, we_c, cmd_start_c, cmd_stop_c;

  // One register write per CPU access: act on the rising edge of the qualifier only
  assign wq_c        = cs_i & ~wr_n_i;
  assign we_c        = wq_c & ~wq_q;
  assign cmd_stop_c  = we_c && (addr_i == 2'd2) && din_i[1];
  assign cmd_start_c = we_c && (addr_i == 2'd2) && din_i[0] && !din_i[1];

  always_comb begin
    state_d    = state_q;
    wq_d       = wq_c;
    start_pg_d = start_pg_q;
    end_pg_d   = end_pg_q;
    ptr_d      = ptr_q;
    first_d    = first_q;
    buf_d      = buf_q;
    shift_d    = shift_q;
    full_d     = full_q;
    last_d     = last_q;
    phase_d    = phase_q;
    busy_d     = busy_q;
    pcm_rst_d  = pcm_rst_q;
    pcm_data_d = pcm_data_q;
    pcm_vld_d  = 1'b0;
    underrun_d = underrun_q;

    if (we_c && (addr_i == 2'd0)) start_pg_d = din_i[PW-1:0];
    if (we_c && (addr_i == 2'd1)) end_pg_d   = din_i[PW-1:0];

    if (cmd_stop_c) begin
      state_d   = S_IDLE;
      full_d    = 1'b0;
      busy_d    = 1'b0;
      pcm_rst_d = 1'b1;
    end else if (cmd_start_c) begin
      state_d    = S_REQ;
      first_d    = 1'b1;
      ptr_d      = {start_pg_q, 8'h00};
      full_d     = 1'b0;
      phase_d    = 1'b0;
      last_d     = 1'b0;
      underrun_d = 1'b0;
      busy_d     = 1'b1;
      pcm_rst_d  = 1'b0;
    end else begin
      // Fetch side; the first REQ cycle gives the ROM a cycle to see the new address
      case (state_q)
        S_REQ: begin
          if (first_q) begin
            first_d = 1'b0;
          end else if (rom.rom_ok) begin
            buf_d   = rom.rom_data;
            full_d  = 1'b1;
            state_d = S_HOLD;
            if (ptr_q == {end_pg_q, 8'hFF}) last_d = 1'b1;
            else                            ptr_d  = ptr_q + AW'(1);
          end
        end
        S_HOLD: begin
          if (last_q) begin
            state_d = S_IDLE;
          end else if (!full_q) begin
            state_d = S_REQ;
            first_d = 1'b1;
          end
        end
        default: ;
      endcase

      // Play side; full_d writes above and below never overlap (REQ only runs with full_q = 0)
      if (cen_smp_i && busy_q) begin
        if (phase_q) begin
          pcm_data_d = HI_FIRST ? shift_q[3:0] : shift_q[7:4];
          pcm_vld_d  = 1'b1;
          phase_d    = 1'b0;
        end else if (full_q) begin
          shift_d    = buf_q;
          full_d     = 1'b0;
          pcm_data_d = HI_FIRST ? buf_q[7:4] : buf_q[3:0];
          pcm_vld_d  = 1'b1;
          phase_d    = 1'b1;
        end else if (last_q) begin
          busy_d    = 1'b0;
          pcm_rst_d = 1'b1;
        end else begin
          underrun_d = 1'b1;
        end
      end
    end

    rom_cs_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wq_q       <= 1'b0;
      start_pg_q <= '0;
      end_pg_q   <= '0;
      ptr_q      <= '0;
      first_q    <= 1'b0;
      rom_cs_q   <= 1'b0;
      buf_q      <= '0;
      shift_q    <= '0;
      full_q     <= 1'b0;
      last_q     <= 1'b0;
      phase_q    <= 1'b0;
      busy_q     <= 1'b0;
      pcm_rst_q  <= 1'b1;
      pcm_data_q <= '0;
      pcm_vld_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wq_q       <= wq_d;
      start_pg_q <= start_pg_d;
      end_pg_q   <= end_pg_d;
      ptr_q      <= ptr_d;
      first_q    <= first_d;
      rom_cs_q   <= rom_cs_d;
      buf_q      <= buf_d;
      shift_q    <= shift_d;
      full_q     <= full_d;
      last_q     <= last_d;
      phase_q    <= phase_d;
      busy_q     <= busy_d;
      pcm_rst_q  <= pcm_rst_d;
      pcm_data_q <= pcm_data_d;
      pcm_vld_q  <= pcm_vld_d;
      underrun_q <= underrun_d;
    end
  end

  assign rom.rom_addr = ptr_q;
  assign rom.rom_cs   = rom_cs_q;
  assign dout_o       = {7'd0, busy_q};
  assign busy_o       = busy_q;
  assign pcm_data_o   = pcm_data_q;
  assign pcm_vld_o    = pcm_vld_q;
  assign pcm_rst_o    = pcm_rst_q;
  assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_jtcomsc_pcm_ctrl.sv
// Scoreboard bench for jtcomsc_pcm_ctrl: expected nibbles and fetch addresses are
// queued at each start command and retired as the DUT strobes/fetches.
module tb_jtcomsc_pcm_ctrl;

  localparam int unsigned AW      = 16;
  localparam int          CEN_PER = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b0;
  logic       wr_n = 1'b1;
  logic [1:0] addr = 2'd0;
  logic [7:0] din = 8'd0;
  logic       cen_smp = 1'b0;
  logic [7:0] dout;
  logic       busy;
  logic [3:0] pcm_data;
  logic       pcm_vld;
  logic       pcm_rst;
  logic       underrun;

  jtcomsc_pcm_ctrl_if #(.AW(AW)) rom_if ();

  jtcomsc_pcm_ctrl #(.AW(AW), .HI_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_i       (cs),
    .wr_n_i     (wr_n),
    .addr_i     (addr),
    .din_i      (din),
    .dout_o     (dout),
    .busy_o     (busy),
    .rom        (rom_if),
    .cen_smp_i  (cen_smp),
    .pcm_data_o (pcm_data),
    .pcm_vld_o  (pcm_vld),
    .pcm_rst_o  (pcm_rst),
    .underrun_o (underrun)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [3:0]    sb_nib[$];
  logic [AW-1:0] sb_adr[$];
  bit            stall = 1'b0;
  bit            force_ok = 1'b0;
  bit            wr_first = 1'b0;
  bit            cen_auto = 1'b0;
  int            vld_cnt = 0;
  logic [7:0]    rom_key = 8'h00;
  logic [7:0]    spg = 8'h00;
  logic [7:0]    epg = 8'h00;

  function automatic logic [7:0] rom_byte(input logic [AW-1:0] a, input logic [7:0] k);
    return a[7:0] ^ k;
  endfunction

  assign rom_if.rom_data = rom_byte(rom_if.rom_addr, rom_key);

  // ROM model (answers on the second cycle of a request) plus output monitor
  initial begin : rom_mon
    int lat;
    lat = 0;
    rom_if.rom_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (rom_if.rom_cs && !stall && !wr_first) lat++;
      else lat = 0;
      rom_if.rom_ok = force_ok || (lat >= 2);
      if (pcm_vld) begin
        vld_cnt++;
        if (sb_nib.size() == 0) chk("vld_unexpected", 32'(pcm_vld), 32'h0);
        else chk("nibble", 32'(pcm_data), 32'(sb_nib.pop_front()));
      end
      if (rom_if.rom_cs && rom_if.rom_ok) begin
        if (sb_adr.size() == 0) chk("fetch_unexpected", 32'(rom_if.rom_cs), 32'h0);
        else chk("fetch_addr", 32'(rom_if.rom_addr), 32'(sb_adr.pop_front()));
      end
    end
  end

  initial begin : cen_gen
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      if (cen_auto) begin
        c = (c >= CEN_PER - 1) ? 0 : c + 1;
        cen_smp = (c == 0);
      end else begin
        c = 0;
      end
    end
  end

  task automatic load_sb();
    logic [AW-1:0] a;
    logic [7:0]    b;
    sb_nib.delete();
    sb_adr.delete();
    a = {spg, 8'h00};
    for (int i = 0; i < 65536; i++) begin
      sb_adr.push_back(a);
      b = rom_byte(a, rom_key);
      sb_nib.push_back(b[7:4]);
      sb_nib.push_back(b[3:0]);
      if (a == {epg, 8'hFF}) break;
      a = a + AW'(1);
    end
  endtask

  // Returns at (write edge + 1) when hold == 1
  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d, input int hold, input bit with_cen);
    @(posedge clk);
    #1;
    cs = 1'b1; wr_n = 1'b0; addr = a; din = d; wr_first = 1'b1;
    if (with_cen) cen_smp = 1'b1;
    @(posedge clk);
    #1;
    wr_first = 1'b0;
    if (with_cen) cen_smp = 1'b0;
    if (a == 2'd0) spg = d;
    if (a == 2'd1) epg = d;
    if (a == 2'd2) begin
      if (d[1]) begin
        sb_nib.delete();
        sb_adr.delete();
      end else if (d[0]) begin
        load_sb();
      end
    end
    for (int i = 1; i < hold; i++) begin
      @(posedge clk);
      #1;
    end
    cs = 1'b0; wr_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (busy && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("idle_timeout", 32'(busy), 32'h0);
  endtask

  task automatic wait_vld(input int n, input int budget);
    int t;
    int target;
    t = 0;
    target = vld_cnt + n;
    while (vld_cnt < target && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("vld_timeout", 32'(vld_cnt >= target), 32'h1);
  endtask

  task automatic wait_romcs(input int budget);
    int t;
    t = 0;
    while (!rom_if.rom_cs && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("romcs_timeout", 32'(rom_if.rom_cs), 32'h1);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rom_addr", 32'(rom_if.rom_addr), 32'h0);
    chk("rst_rom_cs", 32'(rom_if.rom_cs), 32'h0);
    chk("rst_pcm_rst", 32'(pcm_rst), 32'h1);
    chk("rst_underrun", 32'(underrun), 32'h0);

    // cen_smp is ignored while idle
    cen_auto = 1'b1;
    n0 = vld_cnt;
    repeat (5 * CEN_PER) @(posedge clk);
    #1;
    chk("idle_vld", 32'(vld_cnt - n0), 32'h0);
    cpu_wr(2'd3, 8'hFF, 1, 1'b0);
    chk("addr3_busy", 32'(busy), 32'h0);

    // Single page 0x12
    rom_key = 8'h00;
    cpu_wr(2'd0, 8'h12, 2, 1'b0);
    cpu_wr(2'd1, 8'h12, 2, 1'b0);
    cpu_wr(2'd2, 8'h01, 1, 1'b0);
    chk("start_busy", 32'(busy), 32'h1);
    chk("start_dout", 32'(dout), 32'h1);
    chk("start_pcm_rst", 32'(pcm_rst), 32'h0);
    chk("start_rom_cs", 32'(rom_if.rom_cs), 32'h1);
    chk("start_rom_addr", 32'(rom_if.rom_addr), 32'h1200);
    wait_idle(600 * CEN_PER);
    chk("pg_end_pcm_rst", 32'(pcm_rst), 32'h1);
    chk("pg_nib_left", 32'(sb_nib.size()), 32'h0);
    chk("pg_adr_left", 32'(sb_adr.size()), 32'h0);

    // Wrap-around FF..00
    rom_key = 8'h5A;
    cpu_wr(2'd0, 8'hFF, 1, 1'b0);
    cpu_wr(2'd1, 8'h00, 1, 1'b0);
    cpu_wr(2'd2, 8'h01, 1, 1'b0);
    chk("wrap_rom_addr", 32'(rom_if.rom_addr), 32'hFF00);
    wait_idle(1100 * CEN_PER);
    chk("wrap_nib_left", 32'(sb_nib.size()), 32'h0);
    chk("wrap_adr_left", 32'(sb_adr.size()), 32'h0);
    chk("wrap_pcm_rst", 32'(pcm_rst), 32'h1);

    // Long write strobe: one start only, so the first byte is fetched during the hold
    @(negedge clk);
    cen_auto = 1'b0;
    cen_smp = 1'b0;
    rom_key = 8'h33;
    cpu_wr(2'd0, 8'h20, 1, 1'b0);
    cpu_wr(2'd1, 8'h20, 1, 1'b0);
    cpu_wr(2'd2, 8'h01, 10, 1'b0);
    chk("hold_rom_addr", 32'(rom_if.rom_addr), 32'h2001);
    chk("hold_rom_cs", 32'(rom_if.rom_cs), 32'h0);
    chk("hold_busy", 32'(busy), 32'h1);

    // Restart coinciding with cen_smp: no strobe, clean restart
    cpu_wr(2'd2, 8'h01, 1, 1'b1);
    chk("collide_vld", 32'(pcm_vld), 32'h0);
    chk("collide_rom_addr", 32'(rom_if.rom_addr), 32'h2000);
    chk("collide_rom_cs", 32'(rom_if.rom_cs), 32'h1);
    @(negedge clk);
    cen_auto = 1'b1;
    wait_idle(600 * CEN_PER);
    chk("collide_nib_left", 32'(sb_nib.size()), 32'h0);

    // Underrun from a stalled ROM
    rom_key = 8'h77;
    cpu_wr(2'd0, 8'h40, 1, 1'b0);
    cpu_wr(2'd1, 8'h40, 1, 1'b0);
    cpu_wr(2'd2, 8'h01, 1, 1'b0);
    wait_vld(10, 20 * CEN_PER);
    stall = 1'b1;
    n0 = vld_cnt;
    repeat (6 * CEN_PER) @(posedge clk);
    #1;
    chk("underrun_flag", 32'(underrun), 32'h1);
    chk("stall_vld_le3", 32'((vld_cnt - n0) <= 3), 32'h1);
    stall = 1'b0;
    wait_idle(700 * CEN_PER);
    chk("under_nib_left", 32'(sb_nib.size()), 32'h0);
    chk("underrun_sticky", 32'(underrun), 32'h1);
    cpu_wr(2'd2, 8'h01, 1, 1'b0);
    chk("underrun_clear", 32'(underrun), 32'h0);

    // Stop while a fetch is outstanding
    wait_vld(6, 20 * CEN_PER);
    stall = 1'b1;
    wait_romcs(20 * CEN_PER);
    cpu_wr(2'd2, 8'h02, 1, 1'b0);
    chk("stop_rom_cs", 32'(rom_if.rom_cs), 32'h0);
    chk("stop_busy", 32'(busy), 32'h0);
    chk("stop_pcm_rst", 32'(pcm_rst), 32'h1);
    stall = 1'b0;
    force_ok = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    force_ok = 1'b0;
    n0 = vld_cnt;
    repeat (5 * CEN_PER) @(posedge clk);
    #1;
    chk("stop_vld", 32'(vld_cnt - n0), 32'h0);
    chk("stop_busy_after", 32'(busy), 32'h0);

    // Asynchronous reset during a fetch
    cpu_wr(2'd2, 8'h01, 1, 1'b0);
    wait_vld(4, 20 * CEN_PER);
    stall = 1'b1;
    wait_romcs(20 * CEN_PER);
    rst_n = 1'b0;
    #1;
    sb_nib.delete();
    sb_adr.delete();
    chk("arst_dout", 32'(dout), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_rom_addr", 32'(rom_if.rom_addr), 32'h0);
    chk("arst_rom_cs", 32'(rom_if.rom_cs), 32'h0);
    chk("arst_pcm_data", 32'(pcm_data), 32'h0);
    chk("arst_pcm_vld", 32'(pcm_vld), 32'h0);
    chk("arst_pcm_rst", 32'(pcm_rst), 32'h1);
    chk("arst_underrun", 32'(underrun), 32'h0);
    stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = vld_cnt;
    repeat (3 * CEN_PER) @(posedge clk);
    #1;
    chk("post_rst_vld", 32'(vld_cnt - n0), 32'h0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/jtcomsc_pcm_ctrl.md
# jtcomsc_pcm_ctrl

Playback sequencer for the 4-bit ADPCM voice channel of the Combat School sound board. It sits on the sound Z80 bus at the Bxxx window, and the CPU programs it with a start page, an end page and a start/stop command. It fetches sample bytes from the sound-sample ROM through a one-byte prefetch buffer. On each sample-rate clock enable it delivers one nibble to the ADPCM decoder, and it reports a busy flag back to the CPU.

## Interface
- AW, 16: ROM byte-address width. Page registers hold address bits [AW-1:8]; legal range is 9..16.
- HI_FIRST, 1: 1 plays the high nibble of each byte first; 0 plays the low nibble first.

Ports:
- clk  in  1  system clock, 24 MHz
- rst_n  in  1  reset, asynchronous, active-low
- cs  in  1  CPU select for this block; held for several clk cycles per access
- wr_n  in  1  CPU write strobe, active-low
- addr  in  2  register index
- din  in  8  CPU write data
- dout  out  8  read data: {7'd0, busy}
- busy  out  1  playback in progress
- rom_addr  out  AW  sample ROM byte address
- rom_cs  out  1  ROM request
- rom_data  in  8  ROM data
- rom_ok  in  1  ROM data valid for the current rom_addr
- cen_smp  in  1  sample-rate clock enable (decoder rate)
- pcm_data  out  4  nibble to the decoder
- pcm_vld  out  1  one-clk strobe; pcm_data is new
- pcm_rst  out  1  decoder reset (1 while idle)
- underrun  out  1  sticky: a sample slot found the buffer empty; cleared by a start command

## Operation
- Write qualifier: wq = cs & ~wr_n. A register write takes effect only on the first cycle of wq (rising-edge detect), so one CPU access produces one write.
- addr 0 sets start_pg. addr 1 sets end_pg; the end page is inclusive. addr 2 is the control register: bit1 = stop, bit0 = start, and stop wins if both are set. addr 3 writes are ignored.
- Start: ptr <= {start_pg, 8'h00}; buffer empty; phase <= 0; last <= 0; underrun <= 0; busy <= 1; pcm_rst <= 0. A start while busy restarts playback cleanly.
- Stop: busy <= 0, pcm_rst <= 1, rom_cs <= 0 immediately (an in-flight fetch is discarded), buffer emptied.
- Fetch FSM has states IDLE, REQ and HOLD.
  - IDLE → REQ on start.
  - In REQ, rom_cs = 1 and rom_addr = ptr. rom_ok is ignored on the first REQ cycle. On a later cycle with rom_ok = 1: buf <= rom_data, full <= 1, then go to HOLD.
  - On that same accept: if ptr == {end_pg, 8'hFF}, set last <= 1; otherwise ptr <= ptr + 1, wrapping from all-ones to 0. Playback therefore continues through address 0 when end_pg < start_pg.
  - HOLD: rom_cs = 0. Go to REQ when full = 0 and last = 0. Go to IDLE when last = 1.
- Play side acts on cen_smp while busy.
  - phase 0, full = 1: shift <= buf, full <= 0, emit the first nibble, phase <= 1.
  - phase 0, full = 0, last = 1: playback is complete. busy <= 0, pcm_rst <= 1, no strobe.
  - phase 0, full = 0, last = 0: underrun. underrun <= 1, no strobe, phase unchanged, pcm_data holds its value.
  - phase 1: emit the second nibble of shift, phase <= 0.
- If a control write and cen_smp fall in the same cycle, the control write wins and no nibble is emitted that cycle.
- While not busy, cen_smp is ignored.

## Timing
- Reset values: dout 0, busy 0, rom_addr 0, rom_cs 0, pcm_data 0, pcm_vld 0, pcm_rst 1, underrun 0. All registers clear asynchronously.
- Start write (wq rises) at cycle T: busy = 1, pcm_rst = 0, rom_cs = 1 and rom_addr = start address all at T+1.
- ROM accept at cycle A (rom_cs & rom_ok, not the first REQ cycle): full = 1 at A+1 and rom_cs = 0 at A+1.
- cen_smp at cycle S: pcm_data and pcm_vld = 1 valid at S+1, with pcm_vld high for exactly one cycle.
- Next fetch: rom_cs rises the cycle after the play side empties the buffer.
- End of playback: busy = 0 and pcm_rst = 1 at S+1 of the terminating slot.
- dout is combinational from busy.
- A 24 MHz clock against a cen_smp rate of at most 8 kHz leaves more than 1000 cycles per byte for the ROM. Any underrun is therefore a ROM-arbiter stall and is flagged, never silently skipped.

## Test plan
- Reset and idle: assert rst_n = 0 mid-fetch → all outputs at their reset values at once; no pcm_vld while idle, even with cen_smp toggling.
- Single page, HI_FIRST = 1: start_pg = 8'h12, end_pg = 8'h12, ROM[i] = i[7:0] → rom_addr sweeps 16'h1200..16'h12FF; 512 strobes in the order 0,0,0,1,0,2..F,F; busy falls on slot 513; pcm_rst = 1.
- Wrap-around: start_pg = 8'hFF, end_pg = 8'h00 → addresses 16'hFF00..16'hFFFF then 16'h0000..16'h00FF; 1024 strobes; busy then clears.
- Stop mid-play: stop written while rom_cs = 1 → rom_cs = 0 and busy = 0 the next cycle; a later rom_ok does not load the buffer; no further pcm_vld.
- Underrun: hold rom_ok = 0 for 3 cen_smp periods → underrun = 1; pcm_vld absent for those phase-0 slots; playback then resumes with the correct nibble order; a restart clears underrun.
- Write edge and collision: hold cs & ~wr_n for 10 cycles with a start command → exactly one restart; a start write coinciding with cen_smp → no strobe that cycle.
